// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : UART transmitter with a TX FIFO, configurable data width,
//            runtime parity mode, 1/2 stop bits and a runtime baud divisor.
//            Frames queued in the FIFO are sent back-to-back with no idle gap.
// Ports    : Clock, Rst         - clock, synchronous active-high reset
//            Divisor            - clocks per bit minus 1
//            ParMode            - 00 none, 01 even, 10 odd, 11 none
//            StopBits           - 0 one stop bit, 1 two stop bits
//            Wr, Datain         - FIFO write strobe and payload
//            Full, Empty, Level - FIFO status (registered-count based)
//            out, busy          - serial line (idles high), frame in progress
//            Overflow           - sticky dropped-write flag (only when the
//                                 UART_TX_OVERFLOW_EN macro is defined)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          Clock,
    input  logic                          Rst,
    input  logic [DIV_W-1:0]              Divisor,
    input  logic [1:0]                    ParMode,
    input  logic                          StopBits,
    input  logic                          Wr,
    input  logic [DATA_W-1:0]             Datain,
    output logic                          Full,
    output logic                          Empty,
    output logic [$clog2(FIFO_DEPTH):0]   Level,
    output logic                          out,
`ifdef UART_TX_OVERFLOW_EN
    output logic                          busy,
    output logic                          Overflow
`else
    output logic                          busy
`endif
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = ADDR_W + 1;
    localparam int BCNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  count_q,  count_d;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_en;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;

    assign w_full  = (count_q == LVL_W'(FIFO_DEPTH));
    assign w_empty = (count_q == '0);
    // A write while full is dropped even if a pop frees a slot this cycle.
    assign w_wr_en = Wr && !w_full;
    assign w_head  = mem_q[rd_ptr_q];

    assign Full  = w_full;
    assign Empty = w_empty;
    assign Level = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({w_wr_en, w_pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= Datain;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t            state_q,    state_d;
    logic [DIV_W-1:0]  baud_q,     baud_d;
    logic [BCNT_W-1:0] bit_q,      bit_d;
    logic [DATA_W-1:0] shreg_q,    shreg_d;
    logic              par_q,      par_d;
    logic [DIV_W-1:0]  div_q,      div_d;
    logic [1:0]        pmode_q,    pmode_d;
    logic              stop2_q,    stop2_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              out_q,      out_d;
    logic              busy_q,     busy_d;

    logic              w_bit_end;
    logic              w_par_en;
    logic              w_load;

    assign w_bit_end = (baud_q == '0);
    assign w_par_en  = (pmode_q == 2'b01) || (pmode_q == 2'b10);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        div_d      = div_q;
        pmode_d    = pmode_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        out_d      = out_q;
        w_load     = 1'b0;
        w_pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                out_d = 1'b1;
                if (!w_empty) begin
                    w_load = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    state_d = S_DATA;
                    baud_d  = div_q;
                    bit_d   = '0;
                    out_d   = shreg_q[0];
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    baud_d = div_q;
                    if (bit_q == BCNT_W'(DATA_W - 1)) begin
                        if (w_par_en) begin
                            state_d = S_PARITY;
                            // par_q holds the even-parity bit; odd mode inverts it.
                            out_d   = (pmode_q == 2'b10) ? ~par_q : par_q;
                        end else begin
                            state_d    = S_STOP;
                            out_d      = 1'b1;
                            stop_cnt_d = stop2_q;
                        end
                    end else begin
                        bit_d   = bit_q + BCNT_W'(1);
                        shreg_d = shreg_q >> 1;
                        out_d   = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    state_d    = S_STOP;
                    baud_d     = div_q;
                    out_d      = 1'b1;
                    stop_cnt_d = stop2_q;
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (stop_cnt_q) begin
                        // Second stop bit still to go.
                        stop_cnt_d = 1'b0;
                        baud_d     = div_q;
                    end else if (!w_empty) begin
                        w_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        out_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                out_d   = 1'b1;
            end
        endcase

        // Frame pop: head entry and line configuration are captured together
        // so mid-frame changes on the config inputs cannot affect this frame.
        if (w_load) begin
            w_pop      = 1'b1;
            shreg_d    = w_head;
            par_d      = ^w_head;
            div_d      = Divisor;
            baud_d     = Divisor;
            pmode_d    = ParMode;
            stop2_d    = StopBits;
            stop_cnt_d = 1'b0;
            state_d    = S_START;
            out_d      = 1'b0;
        end
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            div_q      <= '0;
            pmode_q    <= 2'b00;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            out_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            div_q      <= div_d;
            pmode_q    <= pmode_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;

`ifdef UART_TX_OVERFLOW_EN
    logic overflow_q, overflow_d;

    assign overflow_d = overflow_q | (Wr && w_full);

    always_ff @(posedge Clock) begin
        if (Rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign Overflow = overflow_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed self-checking bench for uart_tx_fifo (default params).
//            Inputs change on the falling edge; outputs are sampled there too.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic        Clock;
    logic        Rst;
    logic [15:0] Divisor;
    logic [1:0]  ParMode;
    logic        StopBits;
    logic        Wr;
    logic [7:0]  Datain;
    logic        Full;
    logic        Empty;
    logic [3:0]  Level;
    logic        out;
    logic        busy;
`ifdef UART_TX_OVERFLOW_EN
    logic        Overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic exp_q[$];

    uart_tx_fifo #(
        .DATA_W     (8),
        .FIFO_DEPTH (8),
        .DIV_W      (16)
    ) dut (
`ifdef UART_TX_OVERFLOW_EN
        .Overflow (Overflow),
`endif
        .Clock    (Clock),
        .Rst      (Rst),
        .Divisor  (Divisor),
        .ParMode  (ParMode),
        .StopBits (StopBits),
        .Wr       (Wr),
        .Datain   (Datain),
        .Full     (Full),
        .Empty    (Empty),
        .Level    (Level),
        .out      (out),
        .busy     (busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Append the expected line bits of one frame (one entry per bit time).
    task automatic add_frame(input logic [7:0] d, input logic [1:0] pm,
                             input logic sb, input logic par);
        exp_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) exp_q.push_back(d[k]);
        if (pm == 2'b01 || pm == 2'b10) exp_q.push_back(par);
        exp_q.push_back(1'b1);
        if (sb) exp_q.push_back(1'b1);
    endtask

    // Index i is the falling edge following the (i+1)-th rising edge after
    // the first write; the first start bit appears at index 0.
    task automatic check_stream(input int per, input int skip, input bit scramble,
                                input int lvl_idx, input int lvl_exp);
        int n;
        n = exp_q.size() * per;
        for (int i = skip; i < n; i++) begin
            chk("out_bit", {31'd0, out}, {31'd0, exp_q[i / per]});
            chk("busy_in_frame", {31'd0, busy}, 32'd1);
            if (i == lvl_idx) chk("level_mid", {28'd0, Level}, lvl_exp);
            if (scramble && i == 0) begin
                Divisor  = Divisor + 16'd7;
                ParMode  = ParMode ^ 2'b11;
                StopBits = ~StopBits;
            end
            @(negedge Clock);
        end
        chk("busy_after_frame", {31'd0, busy}, 32'd0);
        chk("out_idle_after", {31'd0, out}, 32'd1);
    endtask

    task automatic send_one(input logic [7:0] d, input int div, input logic [1:0] pm,
                            input logic sb, input logic par);
        exp_q.delete();
        add_frame(d, pm, sb, par);
        Divisor  = 16'(div);
        ParMode  = pm;
        StopBits = sb;
        Datain   = d;
        Wr       = 1'b1;
        @(negedge Clock);
        Wr = 1'b0;
        chk("empty_after_wr", {31'd0, Empty}, 32'd0);
        chk("level_after_wr", {28'd0, Level}, 32'd1);
        chk("busy_before_start", {31'd0, busy}, 32'd0);
        chk("out_before_start", {31'd0, out}, 32'd1);
        @(negedge Clock);
        chk("empty_after_pop", {31'd0, Empty}, 32'd1);
        check_stream(div + 1, 0, 1'b1, -1, 0);
    endtask

    logic [7:0] vals [10];

    initial begin
        Rst = 1'b1; Wr = 1'b0; Datain = 8'h00;
        Divisor = 16'd3; ParMode = 2'b00; StopBits = 1'b0;
        repeat (3) @(negedge Clock);
        chk("rst_out", {31'd0, out}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_empty", {31'd0, Empty}, 32'd1);
        chk("rst_full", {31'd0, Full}, 32'd0);
        chk("rst_level", {28'd0, Level}, 32'd0);
`ifdef UART_TX_OVERFLOW_EN
        chk("rst_overflow", {31'd0, Overflow}, 32'd0);
`endif
        Rst = 1'b0;
        @(negedge Clock);

        // 8N1, 4 clocks per bit: 0,1,0,1,0,1,0,1,0,1 over 40 cycles.
        send_one(8'h55, 3, 2'b00, 1'b0, 1'b0);
        // 0x07 has three ones: even parity bit 1, odd parity bit 0.
        send_one(8'h07, 1, 2'b01, 1'b0, 1'b1);
        send_one(8'h07, 1, 2'b10, 1'b0, 1'b0);
        // Mode 11 sends no parity bit.
        send_one(8'h07, 1, 2'b11, 1'b0, 1'b0);
        // Two stop bits, one clock per bit: 11 busy cycles.
        send_one(8'hFF, 0, 2'b00, 1'b1, 1'b0);

        // Back-to-back frames: second write coincides with the first pop,
        // so Level stays at 1 until the second frame is popped.
        exp_q.delete();
        add_frame(8'hA5, 2'b00, 1'b0, 1'b0);
        add_frame(8'h3C, 2'b00, 1'b0, 1'b0);
        Divisor = 16'd1; ParMode = 2'b00; StopBits = 1'b0;
        Datain = 8'hA5; Wr = 1'b1;
        @(negedge Clock);
        chk("b2b_level_1", {28'd0, Level}, 32'd1);
        Datain = 8'h3C;
        @(negedge Clock);
        Wr = 1'b0;
        chk("b2b_level_2", {28'd0, Level}, 32'd1);
        check_stream(2, 0, 1'b0, 20, 0);
        chk("b2b_empty_end", {31'd0, Empty}, 32'd1);

        // Fill: the first write is popped at once, so the 9th write fills the
        // FIFO and the 10th is dropped. Nine frames follow, then idle.
        exp_q.delete();
        Divisor = 16'd3; ParMode = 2'b00; StopBits = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vals[i] = 8'(i * 37 + 5);
            if (i < 9) add_frame(vals[i], 2'b00, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            Datain = vals[i];
            Wr     = 1'b1;
            @(negedge Clock);
            if (i == 7) begin
                chk("fill_full_7", {31'd0, Full}, 32'd0);
                chk("fill_level_7", {28'd0, Level}, 32'd7);
            end
            if (i == 8) begin
                chk("fill_full_8", {31'd0, Full}, 32'd1);
                chk("fill_level_8", {28'd0, Level}, 32'd8);
            end
        end
        Wr = 1'b0;
        chk("drop_full", {31'd0, Full}, 32'd1);
        chk("drop_level", {28'd0, Level}, 32'd8);
`ifdef UART_TX_OVERFLOW_EN
        chk("overflow_set", {31'd0, Overflow}, 32'd1);
`endif
        check_stream(4, 8, 1'b0, 40, 7);
        chk("drain_empty", {31'd0, Empty}, 32'd1);
        chk("drain_full", {31'd0, Full}, 32'd0);
`ifdef UART_TX_OVERFLOW_EN
        chk("overflow_sticky", {31'd0, Overflow}, 32'd1);
`endif

        // Reset in the DATA state with one entry still queued.
        Divisor = 16'd3; Datain = 8'h0F; Wr = 1'b1;
        @(negedge Clock);
        Datain = 8'hAA;
        @(negedge Clock);
        Wr = 1'b0;
        repeat (10) @(negedge Clock);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_level", {28'd0, Level}, 32'd1);
        Rst = 1'b1;
        @(negedge Clock);
        Rst = 1'b0;
        chk("abort_out", {31'd0, out}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_empty", {31'd0, Empty}, 32'd1);
        chk("abort_level", {28'd0, Level}, 32'd0);
        chk("abort_full", {31'd0, Full}, 32'd0);
`ifdef UART_TX_OVERFLOW_EN
        chk("abort_overflow", {31'd0, Overflow}, 32'd0);
`endif
        for (int i = 0; i < 60; i++) begin
            @(negedge Clock);
            chk("post_rst_line", {30'd0, busy, out}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
